// File: rtl/ewrapper_read_responder_if.sv
// Emesh inbound request and outbound response signal bundle for the read responder.
// slave: responder side; master: the requester/consumer side.
interface ewrapper_read_responder_if;
  logic        emesh_access_inb;
  logic        emesh_write_inb;
  logic [1:0]  emesh_datamode_inb;
  logic [3:0]  emesh_ctrlmode_inb;
  logic [31:0] emesh_dstaddr_inb;
  logic [31:0] emesh_srcaddr_inb;
  logic [31:0] emesh_data_inb;
  logic        emesh_wr_wait_inb;

  logic        emesh_access_outb;
  logic        emesh_write_outb;
  logic [1:0]  emesh_datamode_outb;
  logic [3:0]  emesh_ctrlmode_outb;
  logic [31:0] emesh_dstaddr_outb;
  logic [31:0] emesh_srcaddr_outb;
  logic [31:0] emesh_data_outb;
  logic        emesh_rd_wait_outb;
  logic        emesh_wr_wait_outb;

  modport slave (
    input  emesh_access_inb, emesh_write_inb, emesh_datamode_inb, emesh_ctrlmode_inb,
    input  emesh_dstaddr_inb, emesh_srcaddr_inb, emesh_data_inb, emesh_wr_wait_inb,
    output emesh_access_outb, emesh_write_outb, emesh_datamode_outb, emesh_ctrlmode_outb,
    output emesh_dstaddr_outb, emesh_srcaddr_outb, emesh_data_outb,
    output emesh_rd_wait_outb, emesh_wr_wait_outb
  );

  modport master (
    output emesh_access_inb, emesh_write_inb, emesh_datamode_inb, emesh_ctrlmode_inb,
    output emesh_dstaddr_inb, emesh_srcaddr_inb, emesh_data_inb, emesh_wr_wait_inb,
    input  emesh_access_outb, emesh_write_outb, emesh_datamode_outb, emesh_ctrlmode_outb,
    input  emesh_dstaddr_outb, emesh_srcaddr_outb, emesh_data_outb,
    input  emesh_rd_wait_outb, emesh_wr_wait_outb
  );
endinterface

// File: rtl/ewrapper_read_responder.sv
// Emesh register-bank read responder: 16x32 bank, 4-deep pending-read queue, write-back responses.
// Optional macro EWRAPPER_MISS_RESP_EN: answer reads to other chips with 32'hDEADBEEF.
//
// state | meaning
// IDLE  | no response on the output
// SEND  | response held on the output until accepted (emesh_wr_wait_inb=0)
module ewrapper_read_responder #(
  parameter logic [11:0] CHIP_ID    = 12'h810,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic                        emesh_clk_inb,
  input  logic                        reset_n,
  ewrapper_read_responder_if.slave    bus,
  output logic                        err_overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_WAIT = CNT_W'(FIFO_DEPTH - 1);
  localparam logic [31:0]      MISS_DATA = 32'hDEADBEEF;

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  typedef struct packed {
    logic [31:0] src;
    logic [31:0] dst;
    logic [1:0]  datamode;
    logic [3:0]  ctrlmode;
    logic        miss;
  } req_t;

  logic             rst_sync_n;
  state_t           state_q, state_d;
  logic             load;
  logic [31:0]      bank [16];
  req_t             fifo_mem [FIFO_DEPTH];
  req_t             req_in, head;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             chip_match, wr_hit, rd_hit, rd_miss, rd_req;
  logic             fifo_empty, fifo_full, push, drop;
  logic [31:0]      out_src, out_dst, out_data;
  logic [1:0]       out_datamode;
  logic [3:0]       out_ctrlmode;

  // Assertion is immediate; release reaches the logic one edge after reset_n rises.
  always_ff @(posedge emesh_clk_inb or negedge reset_n) begin
    if (!reset_n) rst_sync_n <= 1'b0;
    else          rst_sync_n <= 1'b1;
  end

  assign chip_match = (bus.emesh_dstaddr_inb[31:20] == CHIP_ID);
  assign wr_hit     = bus.emesh_access_inb & chip_match & bus.emesh_write_inb;
  assign rd_hit     = bus.emesh_access_inb & chip_match & ~bus.emesh_write_inb;
`ifdef EWRAPPER_MISS_RESP_EN
  assign rd_miss    = bus.emesh_access_inb & ~chip_match & ~bus.emesh_write_inb;
`else
  assign rd_miss    = 1'b0;
`endif
  assign rd_req     = rd_hit | rd_miss;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CNT_FULL);
  assign push       = rd_req & (~fifo_full | load);
  assign drop       = rd_req & fifo_full & ~load;

  assign req_in = '{src:      bus.emesh_srcaddr_inb,
                    dst:      bus.emesh_dstaddr_inb,
                    datamode: bus.emesh_datamode_inb,
                    ctrlmode: bus.emesh_ctrlmode_inb,
                    miss:     rd_miss};
  assign head   = fifo_mem[rd_ptr];

  always_ff @(posedge emesh_clk_inb or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      for (int i = 0; i < 16; i++) bank[i] <= '0;
    end else if (wr_hit) begin
      bank[bus.emesh_dstaddr_inb[5:2]] <= bus.emesh_data_inb;
    end
  end

  always_ff @(posedge emesh_clk_inb) begin
    if (push) fifo_mem[wr_ptr] <= req_in;
  end

  always_ff @(posedge emesh_clk_inb or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      err_overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (load) rd_ptr <= rd_ptr + 1'b1;
      case ({push, load})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop) err_overflow <= 1'b1;
    end
  end

  always_ff @(posedge emesh_clk_inb or negedge rst_sync_n) begin
    if (!rst_sync_n) state_q <= IDLE;
    else             state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!fifo_empty) state_d = SEND;
      SEND:    if (!bus.emesh_wr_wait_inb) state_d = fifo_empty ? IDLE : SEND;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    load = 1'b0;
    case (state_q)
      IDLE:    load = ~fifo_empty;
      SEND:    load = ~bus.emesh_wr_wait_inb & ~fifo_empty;
      default: load = 1'b0;
    endcase
  end

  // Bank is sampled before this edge's write lands, so a coincident write is not seen.
  always_ff @(posedge emesh_clk_inb or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      out_src      <= '0;
      out_dst      <= '0;
      out_data     <= '0;
      out_datamode <= '0;
      out_ctrlmode <= '0;
    end else if (load) begin
      out_src      <= head.src;
      out_dst      <= head.dst;
      out_datamode <= head.datamode;
      out_ctrlmode <= head.ctrlmode;
      out_data     <= head.miss ? MISS_DATA : bank[head.dst[5:2]];
    end
  end

  assign bus.emesh_access_outb   = (state_q == SEND);
  assign bus.emesh_write_outb    = (state_q == SEND);
  assign bus.emesh_datamode_outb = out_datamode;
  assign bus.emesh_ctrlmode_outb = out_ctrlmode;
  assign bus.emesh_dstaddr_outb  = out_src;
  assign bus.emesh_srcaddr_outb  = out_dst;
  assign bus.emesh_data_outb     = out_data;
  assign bus.emesh_rd_wait_outb  = (count >= CNT_WAIT);
  assign bus.emesh_wr_wait_outb  = 1'b0;

endmodule

// File: doc/ewrapper_read_responder.md
EWRAPPER_READ_RESPONDER -- requirements
Module: ewrapper_read_responder

Interface
REQ-001 SHALL have parameter CHIP_ID, default 12'h810: matched against emesh_dstaddr_inb[31:20].
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: pending-read queue depth; only 4 is supported.
REQ-003 SHALL have a single clock and an asynchronous active-low reset.
REQ-004 SHALL have port emesh_clk_inb, input, 1: sole clock; all logic is rising-edge.
REQ-005 SHALL have port reset_n, input, 1: asynchronous active-low reset.
REQ-006 SHALL have ports emesh_access_inb, emesh_write_inb, input, 1 each: incoming transaction valid and write flag.
REQ-007 SHALL have ports emesh_datamode_inb [1:0] and emesh_ctrlmode_inb [3:0], inputs: incoming modes.
REQ-008 SHALL have ports emesh_dstaddr_inb, emesh_srcaddr_inb, emesh_data_inb, input, 32 each: incoming address and data fields.
REQ-009 SHALL have port emesh_wr_wait_inb, input, 1: downstream stall for the response output.
REQ-010 SHALL have outputs emesh_access_outb, emesh_write_outb (1 each), emesh_datamode_outb [1:0], emesh_ctrlmode_outb [3:0], and emesh_dstaddr_outb, emesh_srcaddr_outb, emesh_data_outb (32 each): response transaction.
REQ-011 SHALL have port emesh_rd_wait_outb, output, 1: read-request stall to the upstream sender.
REQ-012 SHALL have port emesh_wr_wait_outb, output, 1: driven constant 0; writes are never stalled.
REQ-013 SHALL have port err_overflow, output, 1: sticky flag, set when a read is dropped.

Function
REQ-014 SHALL contain a 16 x 32-bit register bank, indexed by emesh_dstaddr_inb[5:2].
REQ-015 SHALL define a hit as emesh_access_inb=1 and emesh_dstaddr_inb[31:20]=CHIP_ID.
REQ-016 SHALL write emesh_data_inb into the indexed register at the clock edge of a write hit; datamode is ignored and all 32 bits are written.
REQ-017 SHALL push {srcaddr, dstaddr, datamode, ctrlmode} into the pending FIFO on a read hit (write=0) when count<4.
REQ-018 SHALL drop a read hit arriving with count=4, and set err_overflow.
REQ-019 SHALL drive emesh_rd_wait_outb = (count >= 3), decoded from the count register, which gives one cycle of skid.
REQ-020 SHALL implement the output state machine with states IDLE and SEND:
- IDLE -> SEND when the FIFO is non-empty: pop the FIFO and load the output register.
- In SEND, a beat is accepted on an edge where emesh_wr_wait_inb=0.
- On acceptance: reload from the FIFO if it is non-empty (stay in SEND); otherwise go to IDLE.
REQ-021 SHALL form the response as follows:
- write_outb=1.
- dstaddr_outb = request srcaddr; srcaddr_outb = request dstaddr.
- datamode and ctrlmode echo the request.
- data_outb = register value sampled at the load edge.
REQ-022 SHALL hold every emesh_*_outb field stable while emesh_access_outb=1 and emesh_wr_wait_inb=1.
REQ-023 SHALL have a latency of 1 cycle when the FIFO is empty and the state is IDLE: a read sampled at edge N gives emesh_access_outb=1 after edge N+1.
REQ-024 SHALL sustain one response per cycle while emesh_wr_wait_inb=0 and the FIFO is non-empty.
REQ-025 SHALL handle a push and a pop on the same edge by leaving count unchanged; a push at count=4 with a simultaneous pop is accepted.
REQ-026 SHALL return the old register value when a write hit to a register coincides with the load of a response that reads it; a later write may overtake an earlier queued read.
REQ-027 SHALL wrap the FIFO pointers modulo 4.
REQ-028 SHALL ignore non-hit transactions, except as given in REQ-034.

Reset
REQ-029 SHALL, while reset_n=0, clear all registers: bank=0, FIFO count/pointers=0, state=IDLE, err_overflow=0.
REQ-030 SHALL, while reset_n=0, drive all emesh_*_outb=0 and emesh_rd_wait_outb=0.
REQ-031 SHALL discard a response that is mid-stall when reset is asserted, together with all queued reads.
REQ-032 SHALL release reset with a single synchronizer; logic becomes active on the second edge after reset_n rises.

Configuration
REQ-033 SHALL gate miss responses with macro EWRAPPER_MISS_RESP_EN.
REQ-034 SHALL, when EWRAPPER_MISS_RESP_EN is defined, queue a read with access=1 and a dstaddr[31:20] mismatch as a response with data_outb=32'hDEADBEEF, through the same FIFO, wait rules and overflow rules as REQ-017..REQ-019.
REQ-035 SHALL, when EWRAPPER_MISS_RESP_EN is undefined, ignore such misses.

Verification
REQ-036 SHALL verify write then read: write 0x81000008 with data 0xCAFEF00D, then read 0x81000008 with srcaddr 0x80800000 -> one cycle later the response is access=1, dst=0x80800000, src=0x81000008, data=0xCAFEF00D.
REQ-037 SHALL verify the stall: wr_wait_inb=1 for 5 cycles during a response -> outputs stay frozen for 5 cycles and the response is accepted once wait drops.
REQ-038 SHALL verify overflow: 6 back-to-back reads with wr_wait_inb=1 -> rd_wait_outb=1 once count reaches 3, count saturates at 4, and err_overflow=1.
REQ-039 SHALL verify throughput: 4 queued reads with wr_wait_inb=0 -> 4 responses on 4 consecutive cycles, in order.
REQ-040 SHALL verify the miss path: read 0x90000000 -> no response without EWRAPPER_MISS_RESP_EN; data 0xDEADBEEF with it.
REQ-041 SHALL verify reset mid-operation: reset_n low while 3 reads are queued -> access_outb=0 and no further responses after release.
